// File: rtl/wb_defs.sv
// Bus-wide constants shared by the Wishbone mux and its slaves, plus the
// timer register map and the byte-lane merge used for partial writes.
package wb_defs;

  localparam logic [31:0] WB_WRONG_DATA = 32'hDEADBEAF;

  typedef enum logic [1:0] {
    TAG_RAM   = 2'd0,
    TAG_TIMER = 2'd1,
    TAG_UART  = 2'd2
  } wb_tag_e;

  // Timer register word offsets (address bits [4:2])
  localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
  localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
  localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] TMR_CTRL        = 3'd4;
  localparam logic [2:0] TMR_PRESCALE    = 3'd5;

  typedef struct packed {
    logic irq_en;
    logic enable;
  } tmr_ctrl_t;

  function automatic logic [31:0] wb_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  sel);
    wb_merge = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) wb_merge[8*b +: 8] = new_v[8*b +: 8];
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every (prescale+1) enabled cycles.
module wb_timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_tick
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic                      w_hit;

  assign w_hit  = (r_cnt == i_prescale);
  assign o_tick = i_en & w_hit;

  // Clearing on a prescale write keeps r_cnt <= i_prescale at all times
  always_ff @(posedge clk_i) begin
    if (rst_i)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= w_hit ? '0 : r_cnt + PRESCALE_WIDTH'(1);
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone classic slave: 64-bit RISC-V mtime/mtimecmp with prescaler and
// a registered level interrupt.
module wb_timer
  import wb_defs::*;
#(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     timer_irq_o
);

  logic                      r_ack;
  logic [WB_DATA_WIDTH-1:0]  r_rdata;
  logic [63:0]               r_mtime;
  logic [63:0]               r_mtimecmp;
  logic [31:0]               r_snap;
  tmr_ctrl_t                 r_ctrl;
  logic [PRESCALE_WIDTH-1:0] r_pre;
  logic                      r_irq;

  logic        w_req, w_acc, w_wr, w_rd, w_tick, w_pre_clr;
  logic [2:0]  w_idx;
  logic [31:0] w_rdata, w_old, w_wdata;
  logic [63:0] w_mtime_nxt;
  logic        w_unused_addr;

  assign w_unused_addr = &{1'b0, wb_addr_i[WB_ADDR_WIDTH-1:5], wb_addr_i[1:0]};

  assign w_req     = wb_stb_i & wb_cyc_i;
  assign w_acc     = w_req & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_rd      = w_acc & ~wb_we_i;
  assign w_idx     = wb_addr_i[4:2];
  assign w_pre_clr = w_wr & (w_idx == TMR_PRESCALE);

  wb_timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_presc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_en      (r_ctrl.enable),
    .i_clr     (w_pre_clr),
    .i_prescale(r_pre),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_rdata = WB_WRONG_DATA;
    case (w_idx)
      TMR_MTIME_LO:    w_rdata = r_mtime[31:0];
      TMR_MTIME_HI:    w_rdata = r_snap;
      TMR_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      TMR_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      TMR_CTRL:        w_rdata = {30'b0, r_ctrl};
      TMR_PRESCALE:    w_rdata = 32'(r_pre);
      default:         w_rdata = WB_WRONG_DATA;
    endcase
  end

  // Merge base is the live register, not the read view (MTIME_HI reads the snapshot)
  always_comb begin
    w_old = '0;
    case (w_idx)
      TMR_MTIME_LO:    w_old = r_mtime[31:0];
      TMR_MTIME_HI:    w_old = r_mtime[63:32];
      TMR_MTIMECMP_LO: w_old = r_mtimecmp[31:0];
      TMR_MTIMECMP_HI: w_old = r_mtimecmp[63:32];
      TMR_CTRL:        w_old = {30'b0, r_ctrl};
      TMR_PRESCALE:    w_old = 32'(r_pre);
      default:         w_old = '0;
    endcase
    w_wdata = wb_merge(w_old, wb_data_i, wb_sel_i);
  end

  // A bus write to either mtime half swallows a coincident tick
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr && w_idx == TMR_MTIME_LO)      w_mtime_nxt[31:0]  = w_wdata;
    else if (w_wr && w_idx == TMR_MTIME_HI) w_mtime_nxt[63:32] = w_wdata;
    else if (w_tick)                        w_mtime_nxt        = r_mtime + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_snap     <= '0;
      r_ctrl     <= '0;
      r_pre      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_irq   <= r_ctrl.irq_en & (r_mtime >= r_mtimecmp);
      r_mtime <= w_mtime_nxt;
      if (w_rd) begin
        r_rdata <= w_rdata;
        if (w_idx == TMR_MTIME_LO) r_snap <= r_mtime[63:32];
      end
      if (w_wr) begin
        case (w_idx)
          TMR_MTIMECMP_LO: r_mtimecmp[31:0]  <= w_wdata;
          TMR_MTIMECMP_HI: r_mtimecmp[63:32] <= w_wdata;
          TMR_CTRL:        r_ctrl            <= tmr_ctrl_t'(w_wdata[1:0]);
          TMR_PRESCALE:    r_pre             <= w_wdata[PRESCALE_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign wb_ack_o    = r_ack;
  assign wb_data_o   = r_rdata;
  assign timer_irq_o = r_irq;

endmodule

// File: tb/tb_wb_timer.sv
// Randomized bench for wb_timer against a cycle-level model of the register rules.
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        b_rst;
  logic [31:0] b_addr, b_wdat;
  logic        b_we, b_stb, b_cyc;
  logic [3:0]  b_sel;
  logic        ack, irq;
  logic [31:0] rdat;

  int n_chk = 0;
  int n_bad = 0;

  // reference state
  logic [63:0] m_mtime, m_cmp;
  logic        m_en, m_ie, m_ack, m_irq;
  logic [15:0] m_pre, m_cnt;
  logic [31:0] m_snap, m_rdata;

  always #5 clk = ~clk;

  wb_timer #(
    .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_SEL_WIDTH(4), .PRESCALE_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(b_rst), .wb_addr_i(b_addr), .wb_data_i(b_wdat),
    .wb_we_i(b_we), .wb_sel_i(b_sel), .wb_stb_i(b_stb), .wb_cyc_i(b_cyc),
    .wb_ack_o(ack), .wb_data_o(rdat), .timer_irq_o(irq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Advance the reference by one clock edge using the inputs currently driven
  task automatic model_step();
    logic acc, wr, rd, tick;
    logic [2:0] k;
    logic [31:0] pm;
    if (b_rst) begin
      m_mtime = 0; m_cmp = '1; m_en = 0; m_ie = 0; m_ack = 0; m_irq = 0;
      m_pre = 0; m_cnt = 0; m_snap = 0; m_rdata = 0;
      return;
    end
    acc  = b_stb && b_cyc && !m_ack;
    wr   = acc && b_we;
    rd   = acc && !b_we;
    k    = b_addr[4:2];
    tick = m_en && (m_cnt == m_pre);
    m_irq = m_ie && (m_mtime >= m_cmp);
    if (rd) begin
      case (k)
        0: begin m_rdata = m_mtime[31:0]; m_snap = m_mtime[63:32]; end
        1: m_rdata = m_snap;
        2: m_rdata = m_cmp[31:0];
        3: m_rdata = m_cmp[63:32];
        4: m_rdata = {30'b0, m_ie, m_en};
        5: m_rdata = {16'b0, m_pre};
        default: m_rdata = 32'hDEADBEAF;
      endcase
    end
    if (wr && k == 5) m_cnt = 0;
    else if (m_en)    m_cnt = tick ? 16'd0 : m_cnt + 16'd1;
    if (wr && k == 0)      m_mtime[31:0]  = mrg(m_mtime[31:0], b_wdat, b_sel);
    else if (wr && k == 1) m_mtime[63:32] = mrg(m_mtime[63:32], b_wdat, b_sel);
    else if (tick)         m_mtime        = m_mtime + 64'd1;
    if (wr && k == 2) m_cmp[31:0]  = mrg(m_cmp[31:0], b_wdat, b_sel);
    if (wr && k == 3) m_cmp[63:32] = mrg(m_cmp[63:32], b_wdat, b_sel);
    if (wr && k == 4 && b_sel[0]) begin m_en = b_wdat[0]; m_ie = b_wdat[1]; end
    if (wr && k == 5) begin pm = mrg({16'b0, m_pre}, b_wdat, b_sel); m_pre = pm[15:0]; end
    m_ack = acc;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("ack", ack, m_ack);
    chk("irq", irq, m_irq);
    chk("rdata", rdat, m_rdata);
  endtask

  task automatic bus_wr(input logic [2:0] w, input logic [31:0] d, input logic [3:0] s);
    b_addr = {27'b0, w, 2'b00}; b_wdat = d; b_sel = s; b_we = 1; b_stb = 1; b_cyc = 1;
    step();
    chk("wr_lat", ack, 1'b1);
    b_stb = 0; b_cyc = 0; b_we = 0;
    step();
    chk("wr_pulse", ack, 1'b0);
  endtask

  task automatic bus_rd(input logic [2:0] w, output logic [31:0] d);
    b_addr = {27'b0, w, 2'b00}; b_we = 0; b_stb = 1; b_cyc = 1; b_sel = $urandom_range(0, 15);
    step();
    chk("rd_lat", ack, 1'b1);
    d = rdat;
    b_stb = 0; b_cyc = 0;
    step();
    chk("rd_pulse", ack, 1'b0);
  endtask

  task automatic bus_hold(input logic [2:0] w, input logic we, input int n);
    b_addr = {27'b0, w, 2'b00}; b_we = we; b_stb = 1; b_cyc = 1;
    b_wdat = (w == 3'd5) ? 32'($urandom_range(0, 5)) : $urandom;
    b_sel = $urandom_range(0, 15);
    repeat (n) step();
    b_stb = 0; b_cyc = 0; b_we = 0;
    step();
  endtask

  logic [31:0] exp_rst [8] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'h0, 32'h0, 32'hDEADBEAF, 32'hDEADBEAF};

  initial begin
    logic [31:0] d;
    int n;
    b_rst = 1; b_addr = 0; b_wdat = 0; b_we = 0; b_sel = 0; b_stb = 0; b_cyc = 0;
    step(); step();
    b_rst = 0;
    step();

    for (int w = 0; w < 8; w++) begin
      bus_rd(3'(w), d);
      chk($sformatf("rst_w%0d", w), d, exp_rst[w]);
    end

    bus_wr(3'd2, 32'h11223344, 4'b0101);
    bus_rd(3'd2, d);
    chk("sel_merge", d, 32'hFF22FF44);

    bus_wr(3'd5, 32'd3, 4'hF);
    bus_wr(3'd4, 32'd1, 4'hF);
    repeat (40) step();
    bus_rd(3'd0, d);
    chk("presc_rng", (d >= 9 && d <= 11), 1'b1);
    chk("presc_cnt", d, 32'd10);
    bus_wr(3'd4, 32'd0, 4'hF);
    bus_rd(3'd0, d);
    repeat (20) step();
    bus_rd(3'd0, d);
    chk("hold", d, m_mtime[31:0]);

    bus_wr(3'd0, 32'hFFFFFFF0, 4'hF);
    bus_wr(3'd1, 32'h0, 4'hF);
    bus_wr(3'd5, 32'h0, 4'hF);
    bus_wr(3'd2, 32'h0, 4'hF);
    bus_wr(3'd3, 32'h1, 4'hF);
    bus_wr(3'd4, 32'h3, 4'hF);
    n = 0;
    while (m_mtime < 64'h1_0000_0000 && n < 200) begin step(); n++; end
    if (n >= 200) chk("irq_wait", 1'b0, 1'b1);
    else begin
      chk("irq_pre", irq, 1'b0);
      step();
      chk("irq_rise", irq, 1'b1);
    end
    bus_wr(3'd3, 32'h2, 4'hF);
    chk("irq_drop", irq, 1'b0);

    bus_wr(3'd4, 32'h0, 4'hF);
    bus_wr(3'd0, 32'hFFFFFFFF, 4'hF);
    bus_wr(3'd1, 32'h0, 4'hF);
    bus_wr(3'd5, 32'd7, 4'hF);
    bus_wr(3'd4, 32'd1, 4'hF);
    bus_rd(3'd0, d);
    chk("snap_lo", d, 32'hFFFFFFFF);
    repeat (5) step();
    bus_rd(3'd1, d);
    chk("snap_hi", d, 32'h0);
    bus_rd(3'd0, d);
    bus_rd(3'd1, d);
    chk("snap_hi2", d, 32'h1);

    bus_wr(3'd1, 32'h0, 4'hF);
    bus_wr(3'd5, 32'h0, 4'hF);
    bus_wr(3'd0, 32'h100, 4'hF);
    bus_rd(3'd0, d);
    chk("wr_wins", d, 32'h101);

    for (int i = 0; i < 300; i++) begin
      int op;
      logic [2:0] w;
      logic [31:0] v;
      op = $urandom_range(0, 9);
      w  = 3'($urandom_range(0, 7));
      if (op <= 3) begin
        v = (w == 3'd5) ? 32'($urandom_range(0, 5)) : $urandom;
        bus_wr(w, v, 4'($urandom_range(0, 15)));
      end else if (op <= 6) begin
        bus_rd(w, d);
      end else if (op == 7) begin
        bus_hold(w, 1'b0, $urandom_range(2, 6));
      end else if (op == 8) begin
        bus_hold(w, 1'b1, $urandom_range(2, 6));
      end else begin
        b_addr = {27'b0, w, 2'b00};
        b_stb = $urandom_range(0, 1);
        b_cyc = ~b_stb;
        repeat ($urandom_range(1, 8)) step();
        b_stb = 0; b_cyc = 0;
      end
    end

    b_addr = {27'b0, 3'd2, 2'b00}; b_wdat = 32'h0; b_sel = 4'hF; b_we = 1;
    b_stb = 1; b_cyc = 1; b_rst = 1;
    step();
    chk("rst_ack", ack, 1'b0);
    b_rst = 0; b_stb = 0; b_cyc = 0; b_we = 0;
    step();
    bus_rd(3'd2, d);
    chk("rst_nowr", d, 32'hFFFFFFFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
Wishbone classic slave implementing a 64-bit RISC-V machine timer (mtime/mtimecmp) with a prescaler and a level interrupt. It sits directly downstream of the bus mux on the timer port (address tag 1) and receives the already-gated stb/cyc. It drives timer_irq_o to the CPU interrupt input.

Parameters:
WB_DATA_WIDTH, 32, bus data width; only 32 is supported.
WB_ADDR_WIDTH, 32, bus address width; only bits [4:2] are decoded.
WB_SEL_WIDTH, 4, byte-select width.
PRESCALE_WIDTH, 16, width of the prescaler compare register.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous active-high reset.
wb_addr_i  in  WB_ADDR_WIDTH  address from mux.
wb_data_i  in  WB_DATA_WIDTH  write data.
wb_we_i  in  1  write enable.
wb_sel_i  in  WB_SEL_WIDTH  byte lanes.
wb_stb_i  in  1  strobe (already qualified by mux decode).
wb_cyc_i  in  1  cycle.
wb_ack_o  out  1  registered acknowledge.
wb_data_o  out  WB_DATA_WIDTH  read data.
timer_irq_o  out  1  machine timer interrupt, level.

Behaviour:
- Register map (word index addr[4:2]): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 enable, bit1 irq_en, others read 0), 5 PRESCALE (low PRESCALE_WIDTH bits, others read 0), 6-7 unmapped.
- Reset values: mtime=0, mtimecmp=all ones, CTRL=0, PRESCALE=0, prescale counter=0, hi snapshot=0, wb_ack_o=0, wb_data_o=0, timer_irq_o=0.
- Handshake: req = wb_stb_i & wb_cyc_i. Next edge: ack <= req & !ack. This gives a 1-cycle latency and a single-cycle ack pulse. A held request is acked every other cycle. Ack drops the cycle after req drops.
- Writes commit on the same edge that sets ack. Each set wb_sel_i bit writes its byte lane; cleared lanes are kept. Writes to read-only bits and unmapped words are ignored, but ack is still given.
- Read data is registered on the ack edge and is valid while ack=1. Unmapped words read 32'hDEADBEAF. wb_data_o holds its value when ack=0.
- Read snapshot: a read of MTIME_LO returns mtime[31:0] and latches mtime[63:32] into the hi snapshot. A read of MTIME_HI returns the snapshot. Software reads LO then HI for a coherent 64-bit value.
- Prescaler: when CTRL.enable=1, the counter increments each cycle. When counter == PRESCALE, the counter clears to 0 and mtime increments by 1. So PRESCALE=0 ticks every cycle and PRESCALE=N ticks every N+1 cycles. When enable=0, the counter and mtime hold.
- mtime wraps from 2^64-1 to 0.
- Simultaneous events: a bus write to MTIME_LO/HI on the tick edge wins; the increment is dropped for that cycle. A write to PRESCALE clears the prescale counter.
- IRQ: timer_irq_o <= CTRL.irq_en & (mtime >= mtimecmp), an unsigned 64-bit compare registered each cycle, so it lags by 1 cycle. It deasserts 1 cycle after mtimecmp is raised above mtime or irq_en is cleared.
- Reset mid-transaction: ack clears on the reset edge and no write commits. The master must reissue the transaction.

Decomposition:
- Shared bus package (wb_defs): WB_WRONG_DATA=32'hDEADBEAF, peripheral tag values (RAM 0, TIMER 1, UART 2), and timer register word offsets. The bus mux consumes the same constants.
- One sub-module: wb_timer_prescaler (enable, prescale value, clear; outputs a tick pulse).

Test Plan:
- Reset then read all 8 words: 0, 0, FFFFFFFF, FFFFFFFF, 0, 0, DEADBEAF, DEADBEAF. Each ack arrives exactly 1 cycle after stb and is 1 cycle wide.
- Write MTIMECMP_LO=0x11223344 with sel=4'b0101, then read: 0xFF22FF44.
- PRESCALE=3, CTRL=1, run 40 cycles, then read MTIME_LO: 10 ±1 (allowing for the access latency). With CTRL=0, mtime is unchanged over the next 20 cycles.
- mtime=0xFFFFFFF0 (hi=0), PRESCALE=0, mtimecmp=0x1_00000000, CTRL=3: irq rises exactly 1 cycle after mtime reaches 0x1_00000000. Writing MTIMECMP_HI=2 drops irq 1 cycle later.
- mtime_lo=0xFFFFFFFF with enable=1: read LO, wait 5 cycles, read HI. HI returns the pre-carry value 0 (the snapshot), not 1.
- With PRESCALE=0 and enable=1, write MTIME_LO=0x100 on a tick edge: an immediate read gives 0x100 (+1 for the read cycle), and no double increment.
